// File: rtl/team_01_pkg.sv
// Shared types and constants for the team_01 Wishbone arbiter.
package team_01_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } arb_state_t;

    localparam int unsigned WB_ADDR_W          = 32;
    localparam int unsigned WB_DATA_W          = 32;
    localparam int unsigned WB_SEL_W           = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/team_01_wb_arbiter_if.sv
// Classic single-beat Wishbone master port of the team_01 wrapper.
interface team_01_wb_arbiter_if;
    import team_01_pkg::*;

    logic [WB_DATA_W-1:0] DAT_I;
    logic                 ACK_I;
    logic [WB_ADDR_W-1:0] ADR_O;
    logic [WB_DATA_W-1:0] DAT_O;
    logic [WB_SEL_W-1:0]  SEL_O;
    logic                 WE_O;
    logic                 STB_O;
    logic                 CYC_O;

    modport master (
        input  DAT_I, ACK_I,
        output ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O
    );

    modport slave (
        output DAT_I, ACK_I,
        input  ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O
    );

endinterface

// File: rtl/team_01_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr, wrapping around.
module team_01_rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = PTR_W'((32'(ptr) + off) % NUM_REQ);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/team_01_wb_arbiter.sv
// Round-robin arbiter sharing the single Wishbone master port between NUM_REQ requesters.
// Optional ACK timeout is built when TEAM_01_WB_ARB_TIMEOUT_EN is defined.
module team_01_wb_arbiter
    import team_01_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                         clk_i,
    input  logic                         nrst,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ-1:0]           we_i,
    input  logic [NUM_REQ*WB_ADDR_W-1:0] adr_i,
    input  logic [NUM_REQ*WB_DATA_W-1:0] wdat_i,
    input  logic [NUM_REQ*WB_SEL_W-1:0]  sel_i,
    output logic [NUM_REQ-1:0]           done_o,
    output logic [NUM_REQ-1:0]           err_o,
    output logic [NUM_REQ-1:0]           gnt_o,
    output logic [WB_DATA_W-1:0]         rdat_o,
    team_01_wb_arbiter_if.master         wb
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    arb_state_t           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, win_idx, ptr_next;
    logic [NUM_REQ-1:0]   pick_gnt;
    logic                 pick_valid;
    logic                 to_hit;
    logic                 win_we;
    logic [WB_ADDR_W-1:0] win_adr;
    logic [WB_DATA_W-1:0] win_dat;
    logic [WB_SEL_W-1:0]  win_sel;

    team_01_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // One-hot winner to index and to its request fields.
    always_comb begin
        win_idx = '0;
        win_we  = 1'b0;
        win_adr = '0;
        win_dat = '0;
        win_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                win_idx = PTR_W'(i);
                win_we  = we_i[i];
                win_adr = adr_i[i*WB_ADDR_W +: WB_ADDR_W];
                win_dat = wdat_i[i*WB_DATA_W +: WB_DATA_W];
                win_sel = sel_i[i*WB_SEL_W +: WB_SEL_W];
            end
        end
        ptr_next = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);
    end

    always_ff @(posedge clk_i or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = BUS;
            BUS:     if (wb.ACK_I || to_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst) begin
        if (!nrst) begin
            ptr_q    <= '0;
            gnt_o    <= '0;
            done_o   <= '0;
            rdat_o   <= '0;
            wb.ADR_O <= '0;
            wb.DAT_O <= '0;
            wb.SEL_O <= '0;
            wb.WE_O  <= 1'b0;
            wb.STB_O <= 1'b0;
            wb.CYC_O <= 1'b0;
        end else begin
            done_o <= '0;
            case (state_q)
                IDLE: begin
                    gnt_o    <= pick_gnt;
                    wb.ADR_O <= win_adr;
                    wb.DAT_O <= win_dat;
                    wb.SEL_O <= win_sel;
                    wb.WE_O  <= win_we;
                    wb.STB_O <= pick_valid;
                    wb.CYC_O <= pick_valid;
                    if (pick_valid) ptr_q <= ptr_next;
                end
                BUS: begin
                    if (wb.ACK_I || to_hit) begin
                        wb.STB_O <= 1'b0;
                        wb.CYC_O <= 1'b0;
                        done_o   <= gnt_o;
                        // ACK wins over a coincident timeout
                        if (wb.ACK_I) begin
                            if (!wb.WE_O) rdat_o <= wb.DAT_I;
                        end else begin
                            rdat_o <= '0;
                        end
                    end
                end
                DONE:    gnt_o <= '0;
                default: ;
            endcase
        end
    end

`ifdef TEAM_01_WB_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    assign to_hit = (state_q == BUS) && !wb.ACK_I && (32'(to_cnt) == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk_i or negedge nrst) begin
        if (!nrst) begin
            to_cnt <= '0;
            err_o  <= '0;
        end else begin
            err_o <= to_hit ? gnt_o : '0;
            if (state_q != BUS)  to_cnt <= '0;
            else if (!wb.ACK_I)  to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_CYCLES;
    assign to_hit         = 1'b0;
    assign err_o          = '0;
`endif

endmodule

// File: tb/tb_team_01_wb_arbiter.sv
// Scoreboard bench for team_01_wb_arbiter: batches of simultaneous requests are predicted
// by a round-robin model; a monitor checks each bus phase and completion pulse.
module tb_team_01_wb_arbiter;
    import team_01_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned TO = 8;
    // Slave returns ADR ^ K, so 0x3300_0010 reads back as 0xDEAD_BEEF.
    localparam logic [31:0] K  = 32'hEDAD_BEFF;

    logic             clk    = 1'b0;
    logic             nrst   = 1'b0;
    logic [N-1:0]     req_i  = '0;
    logic [N-1:0]     we_i   = '0;
    logic [N*32-1:0]  adr_i  = '0;
    logic [N*32-1:0]  wdat_i = '0;
    logic [N*4-1:0]   sel_i  = '0;
    logic [N-1:0]     done_o, err_o, gnt_o;
    logic [31:0]      rdat_o;

    team_01_wb_arbiter_if wb();

    team_01_wb_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i  (clk),
        .nrst   (nrst),
        .req_i  (req_i),
        .we_i   (we_i),
        .adr_i  (adr_i),
        .wdat_i (wdat_i),
        .sel_i  (sel_i),
        .done_o (done_o),
        .err_o  (err_o),
        .gnt_o  (gnt_o),
        .rdat_o (rdat_o),
        .wb     (wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned idx;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] rdat;
        logic        err;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned m_ptr = 0;
    logic [31:0] m_rdat = '0;
    int          forced_wait = -1;
    bit          no_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Wishbone slave: programmable wait states, random stray ACKs outside the bus phase.
    initial begin : slave
        int  w;
        bit  active;
        w = 0;
        active = 1'b0;
        wb.ACK_I = 1'b0;
        wb.DAT_I = '0;
        forever begin
            @(negedge clk);
            if (wb.CYC_O && wb.STB_O) begin
                if (!active) begin
                    active = 1'b1;
                    w = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
                end
                if (no_ack || w > 0) begin
                    wb.ACK_I = 1'b0;
                    wb.DAT_I = $urandom;
                    if (w > 0) w--;
                end else begin
                    wb.ACK_I = 1'b1;
                    wb.DAT_I = wb.ADR_O ^ K;
                end
            end else begin
                active   = 1'b0;
                wb.ACK_I = ($urandom_range(0, 3) == 0);
                wb.DAT_I = $urandom;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        bit   have;
        bit   post_done;
        int   cyc;
        have = 1'b0;
        post_done = 1'b0;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!nrst) begin
                have = 1'b0;
                post_done = 1'b0;
                cyc = 0;
            end else begin
                if (post_done) begin
                    check("idle_gnt", 32'(gnt_o), 32'd0);
                    check("idle_cyc", 32'(wb.CYC_O), 32'd0);
                    post_done = 1'b0;
                end
                if (wb.CYC_O) begin
                    if (!have) begin
                        if (sb.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL bus_unexpected: CYC_O=1 gnt_o=%b, expected idle bus", gnt_o);
                        end else begin
                            e = sb.pop_front();
                            have = 1'b1;
                            cyc = 0;
                        end
                    end
                    if (have) begin
                        cyc++;
                        check("bus_gnt", 32'(gnt_o), 32'(1) << e.idx);
                        check("bus_stb", 32'(wb.STB_O), 32'd1);
                        check("bus_we",  32'(wb.WE_O), 32'(e.we));
                        check("bus_adr", wb.ADR_O, e.adr);
                        check("bus_dat", wb.DAT_O, e.wdat);
                        check("bus_sel", 32'(wb.SEL_O), 32'(e.sel));
                    end
                end
                if (done_o != '0 || err_o != '0) begin
                    if (!have) begin
                        tests++;
                        fails++;
                        $display("FAIL done_unexpected: done_o=%b err_o=%b, expected no completion", done_o, err_o);
                    end else begin
                        check("done_hot", 32'(done_o), 32'(1) << e.idx);
                        check("done_err", 32'(err_o), e.err ? (32'(1) << e.idx) : 32'd0);
                        check("done_rdat", rdat_o, e.rdat);
                        check("done_cyc_low", 32'(wb.CYC_O), 32'd0);
                        if (e.cycles > 0) check("bus_cycles", 32'(cyc), 32'(e.cycles));
                        have = 1'b0;
                        post_done = 1'b1;
                    end
                end
            end
        end
    end

    // Assert a set of requests together; the model predicts service order by a cyclic scan from ptr.
    task automatic run_batch(input logic [N-1:0] set, input logic [N-1:0] we,
                             input logic [N*32-1:0] adr, input logic [N*32-1:0] wdat,
                             input logic [N*4-1:0] sel, input int fw, input bit tmo);
        exp_t         e;
        int unsigned  i;
        int unsigned  last;
        logic [N-1:0] pending;
        int           budget;
        last = m_ptr;
        for (int unsigned off = 0; off < N; off++) begin
            i = (m_ptr + off) % N;
            if (1'(set >> i)) begin
                e.idx  = i;
                e.we   = 1'(we >> i);
                e.adr  = 32'(adr >> (i * 32));
                e.wdat = 32'(wdat >> (i * 32));
                e.sel  = 4'(sel >> (i * 4));
                if (tmo)        m_rdat = '0;
                else if (!e.we) m_rdat = e.adr ^ K;
                e.rdat   = m_rdat;
                e.err    = tmo;
                e.cycles = tmo ? int'(TO) : ((fw >= 0) ? fw + 1 : 0);
                sb.push_back(e);
                last = i;
            end
        end
        m_ptr = (last + 1) % N;
        forced_wait = fw;
        no_ack = tmo;
        @(negedge clk);
        we_i   = we;
        adr_i  = adr;
        wdat_i = wdat;
        sel_i  = sel;
        req_i  = set;
        pending = set;
        budget  = 300;
        while (pending != '0 && budget > 0) begin
            @(negedge clk);
            pending &= ~done_o;
            req_i   &= ~done_o;
            budget--;
        end
        if (pending != '0) begin
            tests++;
            fails++;
            $display("FAIL batch_timeout: requests %b still pending, expected all served", pending);
            req_i = '0;
        end
        no_ack = 1'b0;
        forced_wait = -1;
    endtask

    task automatic run_random(input logic [N-1:0] set, input int fw);
        logic [N*32-1:0] a, d;
        a = '0;
        d = '0;
        for (int k = 0; k < int'(N); k++) begin
            a = (a << 32) | (N*32)'($urandom);
            d = (d << 32) | (N*32)'($urandom);
        end
        run_batch(set, N'($urandom), a, d, (N*4)'($urandom), fw, 1'b0);
    endtask

    task automatic reset_mid_bus();
        exp_t e;
        int   n;
        e.idx = 2; e.we = 1'b0; e.adr = 32'h0000_1230; e.wdat = 32'h0; e.sel = 4'hF;
        e.rdat = '0; e.err = 1'b0; e.cycles = 0;
        sb.push_back(e);
        forced_wait = 20;
        @(negedge clk);
        we_i  = '0;
        adr_i = '0;
        adr_i[95:64] = 32'h0000_1230;
        wdat_i = '0;
        sel_i = '1;
        req_i = 3'b100;
        n = 0;
        while (!wb.CYC_O && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rst_bus_started", 32'(wb.CYC_O), 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("rst_cyc_async", 32'(wb.CYC_O), 32'd0);
        check("rst_stb_async", 32'(wb.STB_O), 32'd0);
        check("rst_gnt_async", 32'(gnt_o), 32'd0);
        req_i = '0;
        sb.delete();
        m_ptr = 0;
        m_rdat = '0;
        forced_wait = -1;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        check("rst_rdat", rdat_o, 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running, tests so far %0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [N*32-1:0] a, d;
        repeat (3) @(negedge clk);
        check("rst_cyc",  32'(wb.CYC_O), 32'd0);
        check("rst_stb",  32'(wb.STB_O), 32'd0);
        check("rst_we",   32'(wb.WE_O), 32'd0);
        check("rst_adr",  wb.ADR_O, 32'd0);
        check("rst_dat",  wb.DAT_O, 32'd0);
        check("rst_sel",  32'(wb.SEL_O), 32'd0);
        check("rst_gnt",  32'(gnt_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err",  32'(err_o), 32'd0);
        check("rst_rdat0", rdat_o, 32'd0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Single read, two wait states.
        a = '0;
        a[31:0] = 32'h3300_0010;
        run_batch(3'b001, 3'b000, a, '0, 12'hFFF, 2, 1'b0);
        check("read_deadbeef", rdat_o, 32'hDEAD_BEEF);

        // Single write on requester 1; rdat_o must keep the previous read.
        d = '0;
        d[63:32] = 32'h1234_5678;
        a = '0;
        a[63:32] = 32'h3300_0020;
        run_batch(3'b010, 3'b010, a, d, 12'h030, 1, 1'b0);
        check("write_keeps_rdat", rdat_o, 32'hDEAD_BEEF);

        // Contention between requesters 0 and 1 over four transactions.
        repeat (2) run_random(3'b011, -1);

        for (int b = 0; b < 40; b++) begin
            run_random(N'($urandom_range(1, (1 << N) - 1)), -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Zero-wait slave and all requesters at once.
        run_random(3'b111, 0);

        reset_mid_bus();
        run_random(3'b011, 0);

`ifdef TEAM_01_WB_ARB_TIMEOUT_EN
        a = '0;
        a[31:0] = 32'h3300_0040;
        run_batch(3'b001, 3'b000, a, '0, 12'hFFF, -1, 1'b1);
        check("timeout_rdat", rdat_o, 32'd0);
        a[31:0] = 32'h3300_0010;
        run_batch(3'b001, 3'b000, a, '0, 12'hFFF, int'(TO) - 1, 1'b0);
        check("ack_at_limit_rdat", rdat_o, 32'hDEAD_BEEF);
`endif

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
